board_loader: RTL and testbench
===============================

Name: board_loader

Overview:
- Parametrised successor to the single-board new-game reset path.
- Copies one selected board image from an external board ROM into object memory, or clears object memory to a fill value.
- Requests ownership of the object-memory write port through a req/grant handshake with the game arbiter.
- Decodes packed 8-bit ROM entries into object-memory words; reports done, error and busy to the game FSM.

Parameters:
- CELLS, 104, object-memory words written per operation (addresses 0..CELLS-1).
- NUM_BOARDS, 8, number of board images in ROM.
- BOARD_STRIDE, 128, ROM words between consecutive board bases; CELLS <= BOARD_STRIDE.
- ROM_AW, 10, ROM address width; NUM_BOARDS*BOARD_STRIDE <= 2**ROM_AW.
- OM_AW, 7, object-memory address width; CELLS <= 2**OM_AW.
- DATA_W, 11, object-memory word width (>= 11).
- ROM_LATENCY, 1, cycles from rom_addr to valid rom_data (1..4).
- FILL, 0, word written in CLEAR mode.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command pulse
- mode  in  1  0=LOAD, 1=CLEAR; sampled with start
- board_sel  in  3  board index; sampled with start
- req  out  1  object-memory port request
- grant  in  1  arbiter grant
- rom_addr  out  ROM_AW  board ROM read address
- rom_data  in  8  packed ROM entry
- om_addr  out  OM_AW  object-memory write address
- om_data  out  DATA_W  object-memory write data
- om_wren  out  1  object-memory write enable
- busy  out  1  high from accepted start through the last write
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset values: req=0, om_wren=0, busy=0, done=0, error=0, rom_addr=0, om_addr=0, om_data=0; state IDLE.
- Reset mid-operation aborts immediately. No om_wren after the reset cycle. Partial object-memory contents are left as written.

State machine: IDLE, REQUEST, COPY, FLUSH.
- IDLE:
  - start with mode=LOAD and board_sel>=NUM_BOARDS: error=1 for one cycle, stay IDLE, no req.
  - Otherwise start latches mode, sets base=board_sel*BOARD_STRIDE (ROM_AW-bit, no overflow by parameter rule), sets busy=1 and req=1, goes to REQUEST.
- REQUEST:
  - req stays high until grant is sampled high. There is no timeout.
  - On grant: req drops next cycle, state goes to COPY, read counter is zeroed.
- COPY, issue side:
  - One read per cycle at rom_addr=base+i, i=0..CELLS-1.
  - A ROM_LATENCY-deep valid shift register tags each issued read.
- COPY, write side:
  - When a tagged entry emerges, write om_addr=k (k increments 0..CELLS-1) and om_data=decode(rom_data) with om_wren=1.
  - First write is ROM_LATENCY+1 cycles after the grant cycle.
- COPY, CLEAR mode: no ROM reads (rom_addr holds). Writes FILL to k=0..CELLS-1, first write one cycle after the grant cycle.
- FLUSH: entered after the last issue; drains the pipeline.
- Completion:
  - Exactly CELLS writes, on consecutive cycles, no gaps.
  - The cycle after the last write: om_wren=0, busy=0, done=1 for one cycle; return to IDLE.
- Decode:
  - rom_data[7]=1 gives om_data = zero-extended rom_data[6:0].
  - rom_data[7]=0 gives om_data = rom_data[2:0]<<8 (bits 10:8), with all other bits 0.
- start while busy is ignored: no error, no latch.
- start in the same cycle as done's return to IDLE is not possible, because done is asserted from IDLE entry. start in the cycle done is high is accepted.
- grant high while req low is ignored.
- om_addr never exceeds CELLS-1; om_wren is never high outside COPY/FLUSH.

Test Plan:
- LOAD board 2, ROM_LATENCY=1, grant 3 cycles after req → rom_addr 256..359; 104 consecutive writes om_addr 0..103, first 2 cycles after grant; done one cycle after addr 103; busy low same cycle.
- Decode: ROM entries 0x85, 0x03, 0xFF → om_data 0x005, 0x300, 0x07F.
- CLEAR mode with FILL=0x7FF → no ROM address change; 104 writes of 0x7FF; done; error never asserted.
- LOAD board_sel=7 with NUM_BOARDS=6 → error one cycle, req never high, no writes; then valid start works normally.
- Reset asserted after the 50th write → next cycle om_wren=0, req=0, busy=0, done=0; a subsequent full load completes correctly.
- ROM_LATENCY=3, start repeated while busy → first write 4 cycles after grant, exactly 104 writes, second start ignored, single done.

Source files
------------

// File: rtl/board_loader.sv
// board_loader
//   Copies one board image from the board ROM into object memory, or clears
//   object memory to FILL. It takes the object-memory write port from the game
//   arbiter through a req/grant handshake and reports busy/done/error to the
//   game FSM.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   start             one-cycle command pulse (mode/board_sel sampled with it)
//   mode              0 = LOAD board image, 1 = CLEAR to FILL
//   board_sel         board index for LOAD
//   req / grant       object-memory port request / arbiter grant
//   rom_addr/rom_data board ROM read port (data valid ROM_LATENCY cycles later)
//   om_addr/om_data/om_wren  object-memory write port
//   busy              high from accepted start through the last write
//   done              one-cycle pulse the cycle after the last write
//   error             one-cycle pulse on a LOAD with an out-of-range board
module board_loader #(
    parameter int unsigned      CELLS        = 104,
    parameter int unsigned      NUM_BOARDS   = 8,
    parameter int unsigned      BOARD_STRIDE = 128,
    parameter int unsigned      ROM_AW       = 10,
    parameter int unsigned      OM_AW        = 7,
    parameter int unsigned      DATA_W       = 11,
    parameter int unsigned      ROM_LATENCY  = 1,
    parameter logic [DATA_W-1:0] FILL        = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [2:0]        board_sel,
    output logic              req,
    input  logic              grant,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [OM_AW-1:0]  om_addr,
    output logic [DATA_W-1:0] om_data,
    output logic              om_wren,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, REQUEST, COPY, FLUSH} state_t;

    localparam logic [OM_AW-1:0] LAST = OM_AW'(CELLS - 1);

    state_t                 state, state_n;
    logic                   mode_q;
    logic [ROM_AW-1:0]      base_q;
    logic [OM_AW-1:0]       rd_cnt;
    logic [OM_AW-1:0]       wr_cnt;
    logic [ROM_LATENCY-1:0] vld;

    logic accept, reject, issue, wr_now, last_wr, sel_bad;
    logic [DATA_W-1:0] decoded;

    assign sel_bad = {29'd0, board_sel} >= NUM_BOARDS;

    // Bit 7 set: literal 7-bit value; clear: 3-bit tag placed at bits 10:8.
    assign decoded = rom_data[7] ? DATA_W'(rom_data[6:0])
                                 : DATA_W'({rom_data[2:0], 8'h00});

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        issue   = 1'b0;
        // CLEAR writes straight from COPY; LOAD writes when a tagged read emerges.
        wr_now  = mode_q ? (state == COPY) : vld[ROM_LATENCY-1];
        last_wr = wr_now && (wr_cnt == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    if (!mode && sel_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = REQUEST;
                    end
                end
            end
            REQUEST: begin
                if (grant) state_n = COPY;
            end
            COPY: begin
                if (mode_q) begin
                    if (last_wr) state_n = IDLE;
                end else begin
                    issue = 1'b1;
                    if (rd_cnt == LAST) state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (last_wr) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= 1'b0;
            base_q   <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            vld      <= '0;
            rom_addr <= '0;
            req      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= reject;
            vld   <= (vld << 1) | ROM_LATENCY'(issue);
            if (accept) begin
                mode_q <= mode;
                base_q <= ROM_AW'(board_sel) * ROM_AW'(BOARD_STRIDE);
                busy   <= 1'b1;
                req    <= 1'b1;
            end
            if (state == REQUEST && grant) begin
                req    <= 1'b0;
                rd_cnt <= '0;
                wr_cnt <= '0;
                if (!mode_q) rom_addr <= base_q;
            end
            // rom_addr stays on the last board entry once all reads are issued.
            if (issue && rd_cnt != LAST) begin
                rd_cnt   <= rd_cnt + 1'b1;
                rom_addr <= rom_addr + 1'b1;
            end
            if (wr_now) wr_cnt <= last_wr ? '0 : wr_cnt + 1'b1;
            if (last_wr) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign om_wren = wr_now;
    assign om_addr = wr_cnt;
    assign om_data = !wr_now ? '0 : (mode_q ? FILL : decoded);

endmodule

// File: tb/tb_board_loader.sv
// Bench for board_loader: ROM model with configurable latency, random board
// contents, expected object-memory words computed from the decode rule.
module tb_board_loader;

    localparam int unsigned CELLS  = 104;
    localparam int unsigned NB     = 6;
    localparam int unsigned STRIDE = 128;
    localparam int unsigned LAT    = 3;
    localparam logic [10:0] FILL_W = 11'h7FF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       grant = 1'b0;
    logic [2:0] board_sel = 3'd0;
    logic       req, om_wren, busy, done, error;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic [6:0] om_addr;
    logic [10:0] om_data;

    logic [7:0] rom_mem  [0:1023];
    logic [7:0] rom_pipe [0:LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    board_loader #(
        .CELLS(CELLS), .NUM_BOARDS(NB), .BOARD_STRIDE(STRIDE), .ROM_AW(10),
        .OM_AW(7), .DATA_W(11), .ROM_LATENCY(LAT), .FILL(FILL_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .board_sel(board_sel), .req(req), .grant(grant),
        .rom_addr(rom_addr), .rom_data(rom_data), .om_addr(om_addr),
        .om_data(om_data), .om_wren(om_wren), .busy(busy), .done(done),
        .error(error)
    );

    // Board ROM: address presented in cycle c gives data in cycle c+LAT.
    always @(posedge clk) begin
        rom_pipe[0] <= rom_mem[rom_addr];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ref_word(input bit clr, input int unsigned sel,
                                             input int unsigned k);
        int unsigned b;
        if (clr) return FILL_W;
        b = rom_mem[sel*STRIDE + k];
        if (b >= 128) return 11'(b - 128);
        return 11'((b % 8) * 256);
    endfunction

    task automatic run_op(input bit clr, input int unsigned sel, input int unsigned gdly,
                          input bit poke, input int unsigned rst_after);
        int unsigned nwr, last_j, ndone, nerr, nbusy_low;
        logic [9:0] held;
        bit bad_sel;
        nwr = 0; last_j = 0; ndone = 0; nerr = 0; nbusy_low = 0;
        bad_sel = !clr && (sel >= NB);

        @(negedge clk);
        start = 1'b1; mode = clr; board_sel = 3'(sel);
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); board_sel = 3'($urandom);
        check("error_pulse", error, bad_sel);
        check("req_after_start", req, !bad_sel);
        check("busy_after_start", busy, !bad_sel);
        if (bad_sel) begin
            for (int j = 0; j < 6; j++) begin
                @(negedge clk);
                if (req || om_wren || busy || error || done) nerr++;
            end
            check("rejected_quiet", nerr, 0);
            return;
        end

        held = rom_addr;
        for (int j = 0; j < int'(gdly); j++) begin
            @(negedge clk);
            if (!req || om_wren) nerr++;
        end
        check("req_held", nerr, 0);
        grant = 1'b1;

        for (int j = 1; j <= int'(CELLS + LAT + 4); j++) begin
            @(negedge clk);
            if (j == 1) begin
                grant = 1'b0;
                check("req_drop", req, 0);
            end
            if (poke && j == 5) begin
                start = 1'b1; mode = 1'($urandom); board_sel = 3'($urandom);
            end
            if (poke && j == 6) start = 1'b0;
            if (om_wren) begin
                if (nwr == 0) check("first_write_cycle", j, clr ? 1 : LAT + 1);
                else          check("write_gap", j, last_j + 1);
                check("om_addr", om_addr, nwr);
                check("om_data", om_data, ref_word(clr, sel, nwr));
                if (!busy) nbusy_low++;
                last_j = j;
                nwr++;
            end
            if (clr && rom_addr !== held) nerr++;
            if (error) nerr++;
            if (done) begin
                ndone++;
                check("done_cycle", j, last_j + 1);
                check("busy_at_done", busy, 0);
            end
            if (rst_after != 0 && nwr == rst_after) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("abort_wren", om_wren, 0);
                check("abort_req", req, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_addr", om_addr, 0);
                return;
            end
        end
        check("write_count", nwr, CELLS);
        check("done_count", ndone, 1);
        check("busy_during_writes", nbusy_low, 0);
        check("side_effects", nerr, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'($urandom);
        rom_mem[256] = 8'h85;
        rom_mem[257] = 8'h03;
        rom_mem[258] = 8'hFF;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_wren", om_wren, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_om_addr", om_addr, 0);
        check("rst_om_data", om_data, 0);
        reset = 1'b0;

        // grant with no request outstanding must not start anything
        grant = 1'b1;
        repeat (2) @(negedge clk);
        grant = 1'b0;
        check("idle_grant_req", req, 0);
        check("idle_grant_wren", om_wren, 0);

        check("decode_85", ref_word(0, 2, 0), 11'h005);
        check("decode_03", ref_word(0, 2, 1), 11'h300);
        check("decode_FF", ref_word(0, 2, 2), 11'h07F);

        run_op(0, 2, 3, 0, 0);
        run_op(1, 7, 2, 0, 0);
        run_op(0, 7, 1, 0, 0);
        run_op(0, 6, 1, 0, 0);
        run_op(0, 5, 0, 0, 0);
        run_op(0, 4, 2, 1, 0);
        run_op(0, 1, 2, 0, 50);
        run_op(0, 1, 2, 0, 0);
        repeat (8) run_op(1'($urandom), $urandom_range(0, NB - 1), $urandom_range(0, 6),
                          1'($urandom), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
